// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port unified RAM.
//
// Requester 0 is the CPU (fetch and load/store). Requester 1 is the program
// loader/debug port. Accesses are serialised. When both requesters ask at once,
// round-robin picks the winner. The arbiter waits out the fixed RAM read
// latency and returns read data only to the requester that issued the read.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req*/we*/addr*/wdata*       requester command inputs (0 = CPU, 1 = loader)
//   gnt*                        access issued this cycle (ACCESS state)
//   rvalid*/rdata*              one-cycle read-data pulse / held read data
//   mem_en/mem_we/mem_addr/     RAM command, driven only in ACCESS
//   mem_wdata
//   mem_rdata                   RAM read data, READ_LATENCY cycles after mem_en
//   busy                        high in every state except IDLE
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [WIDTH-1:0]      rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [WIDTH-1:0]      rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : gen_bad_latency
    $error("mem_arbiter: READ_LATENCY must be in 1..4");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // WAIT ends when the counter reaches this value.
  localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

  logic [1:0] state;
  logic       sel;
  logic       last_grant;
  logic [2:0] cnt;

  logic arb_any;
  logic arb_win;
  logic we_sel;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    arb_any = req0 | req1;
    if (req0 && req1) begin
      arb_win = ~last_grant;
    end else begin
      arb_win = req1;
    end
  end

  assign we_sel = sel ? we1 : we0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 3'd0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (arb_any) begin
            sel        <= arb_win;
            last_grant <= arb_win;
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          cnt   <= 3'd0;
          state <= we_sel ? IDLE : WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= 3'd0;
            state <= RESP;
            if (sel) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = we_sel;
      mem_addr  = sel ? addr1 : addr0;
      mem_wdata = sel ? wdata1 : wdata0;
      gnt0      = ~sel;
      gnt1      = sel;
    end
    if (state == RESP) begin
      rvalid0 = ~sel;
      rvalid1 = sel;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

  logic        a_gnt0, a_rvalid0, a_gnt1, a_rvalid1, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_gnt0, b_rvalid0, b_gnt1, b_rvalid1, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // RAM model: data read in the access cycle appears exactly READ_LATENCY
  // cycles later and is 0 in every other cycle, so a mistimed capture is visible.
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  logic [31:0] ram [0:63];
  logic [3:0]  a_pv = '0, b_pv = '0;
  logic [31:0] a_pd [0:3];
  logic [31:0] b_pd [0:3];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr[7:2]] <= pre_data;
    if (a_mem_en && a_mem_we) ram[a_mem_addr[7:2]] <= a_mem_wdata;
    if (b_mem_en && b_mem_we) ram[b_mem_addr[7:2]] <= b_mem_wdata;
    a_pv <= {a_pv[2:0], a_mem_en & ~a_mem_we};
    b_pv <= {b_pv[2:0], b_mem_en & ~b_mem_we};
    a_pd[0] <= ram[a_mem_addr[7:2]];
    b_pd[0] <= ram[b_mem_addr[7:2]];
    for (int i = 1; i < 4; i++) begin
      a_pd[i] <= a_pd[i-1];
      b_pd[i] <= b_pd[i-1];
    end
  end

  assign a_mem_rdata = a_pv[0] ? a_pd[0] : '0;
  assign b_mem_rdata = b_pv[2] ? b_pd[2] : '0;

  // Scoreboard for instance a: expected read responses with their cycle.
  typedef struct {
    int          id;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  always @(negedge clk) begin
    if (a_rvalid0 || a_rvalid1) begin
      checks++;
      if (sbq.size() == 0) begin
        $display("FAIL unexpected_rvalid cycle %0d: rvalid0=%0b rvalid1=%0b, required none",
                 cyc, a_rvalid0, a_rvalid1);
      end else begin
        e = sbq.pop_front();
        if ((a_rvalid0 && a_rvalid1) || (a_rvalid1 ? 1 : 0) != e.id)
          $display("FAIL rvalid_route: rvalid0=%0b rvalid1=%0b, required id %0d",
                   a_rvalid0, a_rvalid1, e.id);
        else if (cyc != e.at)
          $display("FAIL rvalid_cycle: got %0d, required %0d", cyc, e.at);
        else if ((e.id == 1 ? a_rdata1 : a_rdata0) !== e.data)
          $display("FAIL rdata: got %h, required %h", e.id == 1 ? a_rdata1 : a_rdata0, e.data);
        else
          passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({a_busy, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_rvalid0, a_rvalid1} !== 7'd0)
      $display("FAIL reset_ctrl_a: got %b, required 0",
               {a_busy, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_rvalid0, a_rvalid1});
    else passed++;
    checks++;
    if ({a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata} !== 128'd0)
      $display("FAIL reset_data_a: rdata0=%h rdata1=%h addr=%h wdata=%h, required 0",
               a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata);
    else passed++;
    checks++;
    if ({b_busy, b_gnt0, b_gnt1, b_mem_en, b_rvalid0, b_rvalid1, b_rdata0, b_rdata1} !== 70'd0)
      $display("FAIL reset_b: busy=%b rdata0=%h rdata1=%h, required 0", b_busy, b_rdata0, b_rdata1);
    else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int n;
    do_reset();
    poke(32'h10, 32'hDEADBEEF);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    n = cyc;
    sbq.push_back('{0, 32'hDEADBEEF, n + 3});
    step();
    @(negedge clk);
    checks++;
    if ({a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_busy} !== 5'b10101)
      $display("FAIL read_grant: gnt0,gnt1,en,we,busy=%b, required 10101",
               {a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_busy});
    else passed++;
    checks++;
    if (a_mem_addr !== 32'h10) $display("FAIL read_addr: got %h, required 00000010", a_mem_addr);
    else passed++;
    step();
    req0 = 0;
    wait_drain();
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL read_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
    checks++;
    if ({a_rdata0, a_rdata1} !== {32'hDEADBEEF, 32'h0})
      $display("FAIL read_hold: rdata0=%h rdata1=%h, required deadbeef 0", a_rdata0, a_rdata1);
    else passed++;
  endtask

  task automatic test_round_robin();
    int  n;
    logic g0, g1;
    do_reset();
    poke(32'h20, 32'h11110000);
    poke(32'h24, 32'h22220001);
    req0 = 1; we0 = 0; addr0 = 32'h20;
    req1 = 1; we1 = 0; addr1 = 32'h24;
    n = cyc;
    sbq.push_back('{0, 32'h11110000, n + 3});
    sbq.push_back('{1, 32'h22220001, n + 6});
    sbq.push_back('{0, 32'h11110000, n + 9});
    sbq.push_back('{1, 32'h22220001, n + 12});
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 11) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      g0 = (k == 1 || k == 7);
      g1 = (k == 4 || k == 10);
      checks++;
      if ({a_gnt0, a_gnt1} !== {g0, g1})
        $display("FAIL rr_grant k=%0d: gnt0,gnt1=%b, required %b", k, {a_gnt0, a_gnt1}, {g0, g1});
      else passed++;
      if (g0 || g1) begin
        checks++;
        if (a_mem_addr !== (g1 ? 32'h24 : 32'h20))
          $display("FAIL rr_addr k=%0d: got %h, required %h", k, a_mem_addr, g1 ? 32'h24 : 32'h20);
        else passed++;
      end
    end
    wait_drain();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL rr_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  task automatic test_write();
    int n;
    do_reset();
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h12345678;
    step();
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_mem_we, a_gnt1, a_gnt0, a_busy} !== 5'b11101)
      $display("FAIL wr_ctrl: en,we,gnt1,gnt0,busy=%b, required 11101",
               {a_mem_en, a_mem_we, a_gnt1, a_gnt0, a_busy});
    else passed++;
    checks++;
    if ({a_mem_addr, a_mem_wdata} !== {32'h40, 32'h12345678})
      $display("FAIL wr_bus: addr=%h wdata=%h, required 00000040 12345678", a_mem_addr, a_mem_wdata);
    else passed++;
    step();
    req1 = 0; we1 = 0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_mem_en, a_mem_we, a_gnt1, a_rvalid1} !== 5'd0)
      $display("FAIL wr_done: busy,en,we,gnt1,rvalid1=%b, required 0",
               {a_busy, a_mem_en, a_mem_we, a_gnt1, a_rvalid1});
    else passed++;
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_rdata1} !== 96'd0)
      $display("FAIL wr_idle_bus: addr=%h wdata=%h rdata1=%h, required 0",
               a_mem_addr, a_mem_wdata, a_rdata1);
    else passed++;
    step();
    req0 = 1; we0 = 0; addr0 = 32'h40;
    n = cyc;
    sbq.push_back('{0, 32'h12345678, n + 3});
    step();
    step();
    req0 = 0;
    wait_drain();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL wr_readback_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  task automatic test_latency3();
    int n;
    do_reset();
    poke(32'h30, 32'hCAFEF00D);
    req0 = 1; we0 = 0; addr0 = 32'h30;
    n = cyc;
    sbq.push_back('{0, 32'hCAFEF00D, n + 3});
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) req0 = 0;
      @(negedge clk);
      checks++;
      if ({b_gnt0, b_mem_en, b_rvalid0, b_gnt1, b_rvalid1} !== {k == 1, k == 1, k == 5, 2'b00})
        $display("FAIL lat3 k=%0d: gnt0,en,rvalid0,gnt1,rvalid1=%b, required %b", k,
                 {b_gnt0, b_mem_en, b_rvalid0, b_gnt1, b_rvalid1}, {k == 1, k == 1, k == 5, 2'b00});
      else passed++;
      if (k == 5) begin
        checks++;
        if (b_rdata0 !== 32'hCAFEF00D)
          $display("FAIL lat3_rdata: got %h, required cafef00d", b_rdata0);
        else passed++;
      end
    end
    wait_drain();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL lat3_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  task automatic test_reset_in_wait();
    int n;
    do_reset();
    poke(32'h50, 32'h55AA55AA);
    req0 = 1; we0 = 0; addr0 = 32'h50;
    step();
    @(negedge clk);
    checks++;
    if (a_gnt0 !== 1'b1) $display("FAIL rw_grant: got %b, required 1", a_gnt0);
    else passed++;
    step();
    rst = 1; req0 = 0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1) $display("FAIL rw_in_wait: busy=%b, required 1", a_busy);
    else passed++;
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_rvalid0, a_rvalid1, a_rdata0} !== 39'd0)
      $display("FAIL rw_after_reset: ctrl=%b rdata0=%h, required 0",
               {a_busy, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_rvalid0, a_rvalid1}, a_rdata0);
    else passed++;
    step();
    req0 = 1; addr0 = 32'h50; req1 = 1; we1 = 0; addr1 = 32'h54;
    n = cyc;
    sbq.push_back('{0, 32'h55AA55AA, n + 3});
    step();
    @(negedge clk);
    checks++;
    if ({a_gnt0, a_gnt1} !== 2'b10)
      $display("FAIL rw_first_tie: gnt0,gnt1=%b, required 10", {a_gnt0, a_gnt1});
    else passed++;
    step();
    req0 = 0; req1 = 0;
    wait_drain();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL rw_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  task automatic test_drop_req();
    int n;
    do_reset();
    poke(32'h60, 32'h60606060);
    poke(32'h64, 32'h64646464);
    req0 = 1; we0 = 0; addr0 = 32'h60;
    req1 = 1; we1 = 0; addr1 = 32'h64;
    n = cyc;
    sbq.push_back('{0, 32'h60606060, n + 3});
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) req1 = 0;
      if (k == 2) req0 = 0;
      @(negedge clk);
      checks++;
      if ({a_gnt0, a_gnt1} !== {k == 1, 1'b0})
        $display("FAIL drop k=%0d: gnt0,gnt1=%b, required %b", k, {a_gnt0, a_gnt1}, {k == 1, 1'b0});
      else passed++;
    end
    step();
    req1 = 1;
    n = cyc;
    sbq.push_back('{1, 32'h64646464, n + 3});
    step();
    @(negedge clk);
    checks++;
    if ({a_gnt1, a_gnt0, a_mem_addr} !== {2'b10, 32'h64})
      $display("FAIL drop_regrant: gnt1,gnt0=%b addr=%h, required 10 00000064",
               {a_gnt1, a_gnt0}, a_mem_addr);
    else passed++;
    step();
    req1 = 0;
    wait_drain();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL drop_drain: %0d pending, required 0", sbq.size());
      sbq.delete();
    end else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_latency3();
    test_reset_in_wait();
    test_drop_req();
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port unified instruction/data RAM.
- Requester 0 is the multicycle CPU controller/datapath. It issues instruction fetch and load/store accesses.
- Requester 1 is the program loader/debug port.
- The arbiter serialises accesses, applies round-robin fairness on contention, sequences the fixed RAM read latency, and returns read data to the winning requester only.

Parameters:
- WIDTH, 32: data width of wdata, rdata and mem_rdata.
- ADDR_WIDTH, 32: byte address width.
- READ_LATENCY, 1: cycles from the mem_en access cycle to valid mem_rdata. Legal range 1..4; 0 is illegal (elaboration assertion).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0  in  1  CPU access request
- we0  in  1  CPU write enable (1 = store, 0 = read)
- addr0  in  ADDR_WIDTH  CPU address
- wdata0  in  WIDTH  CPU store data
- gnt0  out  1  CPU access issued this cycle
- rvalid0  out  1  CPU read data valid, one-cycle pulse
- rdata0  out  WIDTH  CPU read data
- req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1: same as the *0 ports, for the loader
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid READ_LATENCY cycles after the mem_en cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Reset (sync, rst high at a clk edge) forces:
  - state=IDLE, last_grant=1, sel=0, latency counter=0.
  - gnt*, rvalid*, mem_en, mem_we = 0; rdata0 = rdata1 = 0.
  - An in-flight read is dropped: no rvalid is ever produced for it.
- Arbitration happens only in IDLE and RESP, on the requests sampled in that cycle:
  - Only one requester asserting: it wins.
  - Both asserting: the winner is the requester other than last_grant. After reset the CPU therefore wins the first tie.
  - The winner is registered into sel, and last_grant is updated to sel. Next state is ACCESS.
  - No request: next state is IDLE.
- ACCESS (exactly one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata are driven from the selected requester's live inputs.
  - gnt_sel=1; the other gnt is 0.
  - Next state: WAIT if we_sel=1 is false (read), else IDLE.
- WAIT:
  - Counts READ_LATENCY cycles; mem_en=0.
  - On the edge ending the last WAIT cycle, mem_rdata is captured into rdata_sel.
  - Next state: RESP.
- RESP (one cycle):
  - rvalid_sel=1; rdata_sel holds the captured word.
  - Arbitration runs in this cycle (see above).
- Timing:
  - Read issued in ACCESS cycle T: mem_rdata is sampled at the end of cycle T+READ_LATENCY; rvalid is asserted in cycle T+READ_LATENCY+1.
  - Request sampled in IDLE at cycle N: gnt in cycle N+1.
  - Back-to-back writes: one per 2 cycles.
  - Back-to-back reads: one per READ_LATENCY+2 cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable from assertion through its gnt cycle.
  - A requester deasserts req in the cycle after gnt unless it wants a new access.
  - A req still high in RESP or IDLE after a gnt is treated as a new request.
  - A req dropped before being granted is simply not considered; this is not an error.
  - Requests arriving during ACCESS or WAIT are ignored until the next arbitration point.
- rdata0/rdata1 hold their last captured value until the next read completes for the same requester. A write never alters them.
- Outputs not selected stay 0. mem_addr and mem_wdata are don't-care when mem_en=0, but must not be X in simulation: drive 0.

Test Plan:
- READ_LATENCY=1, only req0, we0=0, addr0=0x10 asserted in IDLE at cycle 0; RAM returns 0xDEADBEEF in cycle 2 -> gnt0 and mem_en high with mem_addr=0x10 in cycle 1; rvalid0 high in cycle 3 with rdata0=0xDEADBEEF; gnt1 and rvalid1 stay 0.
- After reset, req0 and req1 held high continuously as reads -> grant order 0,1,0,1. Each rvalid is routed only to the matching requester, and gnt pulses are READ_LATENCY+2 cycles apart.
- req1 write, addr1=0x40, wdata1=0x12345678 -> mem_en=mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 for exactly one cycle; no rvalid; state returns to IDLE; busy pulses for one cycle.
- READ_LATENCY=3, req0 read -> rvalid0 exactly 4 cycles after gnt0; mem_rdata is sampled 3 cycles after the access.
- rst asserted during WAIT -> the next cycle shows IDLE with all outputs 0; no rvalid for the dropped read; the first tie afterwards goes to requester 0.
- req1 deasserted in the same IDLE cycle in which req0 wins -> gnt1 never pulses; req1 re-asserted later is granted normally.
